// File: rtl/filter_param_pkg.sv
// Shared widths, FSM state type and exponential cutoff knots for the filter parameter conditioner.
package filter_param_pkg;

  localparam int unsigned POT_W  = 10;
  localparam int unsigned KNOT_N = 9;

  typedef logic [POT_W-1:0] pot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLEW,
    ST_MAP,
    ST_OUT
  } state_e;

  localparam logic [KNOT_N-1:0][POT_W-1:0] EXP_KNOTS = {
    10'd1023, 10'd512, 10'd256, 10'd128, 10'd64, 10'd32, 10'd16, 10'd8, 10'd4
  };

  // Piecewise-linear interpolation between octave knots; top 3 bits pick the segment.
  function automatic pot_t exp_map(input pot_t c);
    logic [3:0]       lo;
    logic [3:0]       hi;
    logic [POT_W-1:0] span;
    logic [16:0]      prod;
    lo   = {1'b0, c[POT_W-1 -: 3]};
    hi   = lo + 4'd1;
    span = EXP_KNOTS[hi] - EXP_KNOTS[lo];
    prod = 17'(span) * 17'(c[6:0]);
    return EXP_KNOTS[lo] + POT_W'(prod >> 7);
  endfunction

endpackage

// File: rtl/filter_param_conditioner_pot_slew.sv
// One pot channel: deadbanded target tracking plus step-limited slew of the current value.
module pot_slew
  import filter_param_pkg::*;
#(
  parameter int unsigned SLEW_STEP = 4,
  parameter int unsigned DEADBAND  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POT_W-1:0] raw_i,
  input  logic             slew_en_i,
  output logic [POT_W-1:0] cur_o
);

  localparam int unsigned DW = POT_W + 1;

  logic              first_load_q;
  logic              snap_q;
  pot_t              target_q, target_d;
  pot_t              cur_q, cur_d;
  logic signed [DW-1:0] raw_diff, slew_diff;
  logic [DW-1:0]     raw_mag, slew_mag;

  always_comb begin
    raw_diff  = $signed({1'b0, raw_i}) - $signed({1'b0, target_q});
    raw_mag   = (raw_diff < 0) ? DW'(-raw_diff) : DW'(raw_diff);
    slew_diff = $signed({1'b0, target_q}) - $signed({1'b0, cur_q});
    slew_mag  = (slew_diff < 0) ? DW'(-slew_diff) : DW'(slew_diff);

    target_d = target_q;
    if (first_load_q || (raw_mag > DW'(DEADBAND))) begin
      target_d = raw_i;
    end

    // Step never overshoots: a remaining gap within one step lands exactly on target.
    cur_d = cur_q;
    if (slew_en_i) begin
      if (snap_q || (slew_mag <= DW'(SLEW_STEP))) begin
        cur_d = target_q;
      end else if (slew_diff < 0) begin
        cur_d = cur_q - POT_W'(SLEW_STEP);
      end else begin
        cur_d = cur_q + POT_W'(SLEW_STEP);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_load_q <= 1'b1;
      snap_q       <= 1'b1;
      target_q     <= '0;
      cur_q        <= '0;
    end else begin
      first_load_q <= 1'b0;
      if (slew_en_i) begin
        snap_q <= 1'b0;
      end
      target_q <= target_d;
      cur_q    <= cur_d;
    end
  end

  assign cur_o = cur_q;

endmodule

// File: rtl/filter_param_conditioner.sv
// Conditions cutoff/quality pots for the ladder filter; updates land only on update_strobe_i.
// Optional exponential cutoff map enabled by defining CUTOFF_EXP_MAP_EN.
module filter_param_conditioner
  import filter_param_pkg::*;
#(
  parameter int unsigned SLEW_STEP = 4,
  parameter int unsigned DEADBAND  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POT_W-1:0] pot_cutoff_raw_i,
  input  logic [POT_W-1:0] pot_quality_raw_i,
  input  logic             update_strobe_i,
  output logic [POT_W-1:0] pot_cutoff_o,
  output logic [POT_W-1:0] pot_quality_o,
  output logic             params_valid_o,
  output logic             busy_o
);

  state_e state_q, state_d;
  logic   pending_q, pending_d;
  logic   slew_en_c;
  pot_t   cut_cur, qual_cur;
  pot_t   map_c;
  pot_t   cut_q, qual_q;
  logic   valid_q, busy_q;

  pot_slew #(.SLEW_STEP(SLEW_STEP), .DEADBAND(DEADBAND)) u_cutoff (
    .clk       (clk),
    .rst       (rst),
    .raw_i     (pot_cutoff_raw_i),
    .slew_en_i (slew_en_c),
    .cur_o     (cut_cur)
  );

  pot_slew #(.SLEW_STEP(SLEW_STEP), .DEADBAND(DEADBAND)) u_quality (
    .clk       (clk),
    .rst       (rst),
    .raw_i     (pot_quality_raw_i),
    .slew_en_i (slew_en_c),
    .cur_o     (qual_cur)
  );

  // Sequencer; strobes arriving while busy collapse into a single pending update.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    slew_en_c = 1'b0;
    if ((state_q != ST_IDLE) && update_strobe_i) begin
      pending_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (update_strobe_i || pending_q) begin
          state_d   = ST_SLEW;
          pending_d = 1'b0;
        end
      end
      ST_SLEW: begin
        slew_en_c = 1'b1;
        state_d   = ST_MAP;
      end
      ST_MAP:  state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CUTOFF_EXP_MAP_EN
  always_comb map_c = exp_map(cut_cur);
`else
  always_comb map_c = cut_cur;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      cut_q     <= '0;
      qual_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= (state_q == ST_MAP);
      busy_q    <= (state_d != ST_IDLE);
      if (state_q == ST_MAP) begin
        cut_q  <= map_c;
        qual_q <= qual_cur;
      end
    end
  end

  assign pot_cutoff_o   = cut_q;
  assign pot_quality_o  = qual_q;
  assign params_valid_o = valid_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_filter_param_conditioner.sv
// Directed bench for filter_param_conditioner with a scoreboard of expected parameter updates.
module tb_filter_param_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] cut_raw;
  logic [9:0] q_raw;
  logic       strobe;
  wire  [9:0] cut_o;
  wire  [9:0] q_o;
  wire        valid;
  wire        busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int cut;
    int q;
  } exp_t;

  exp_t       sb[$];
  int         vcyc[$];
  exp_t       mon_e;
  logic [9:0] prev_cut = '0;
  logic [9:0] prev_q   = '0;

  filter_param_conditioner dut (
    .clk               (clk),
    .rst               (rst),
    .pot_cutoff_raw_i  (cut_raw),
    .pot_quality_raw_i (q_raw),
    .update_strobe_i   (strobe),
    .pot_cutoff_o      (cut_o),
    .pot_quality_o     (q_o),
    .params_valid_o    (valid),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_cut(input int c);
`ifdef CUTOFF_EXP_MAP_EN
    int k[9];
    int i;
    int f;
    k = '{4, 8, 16, 32, 64, 128, 256, 512, 1023};
    i = c / 128;
    f = c % 128;
    return k[i] + (((k[i+1] - k[i]) * f) / 128);
`else
    return c;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard on every update pulse; otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid === 1'b1) begin
        vcyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(valid), 0);
        end else begin
          mon_e = sb.pop_front();
          check("sb_cutoff", 32'(cut_o), exp_cut(mon_e.cut));
          check("sb_quality", 32'(q_o), mon_e.q);
        end
      end else begin
        check("stable_cutoff", 32'(cut_o), 32'(prev_cut));
        check("stable_quality", 32'(q_o), 32'(prev_q));
      end
    end
    prev_cut = cut_o;
    prev_q   = q_o;
  end

  task automatic strobe_n(input int len, input int c, input int q, output int n);
    sb.push_back('{c, q});
    if (len > 1) sb.push_back('{c, q});
    @(posedge clk); #1;
    strobe = 1'b1;
    n = cyc;
    repeat (len) @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic settle();
    int budget = 0;
    while (((busy === 1'b1) || (sb.size() != 0)) && (budget < 40)) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("settle_timeout", 32'(budget >= 40), 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pts[3];
    pts = '{0, 128, 1023};
    strobe  = 1'b0;
    cut_raw = 10'd512;
    q_raw   = 10'd100;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cutoff", 32'(cut_o), 0);
    check("rst_quality", 32'(q_o), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // First update after reset snaps to raw; valid exactly three cycles after strobe.
    vcyc.delete();
    strobe_n(1, 512, 100, n);
    check("t1_busy", 32'(busy), 1);
    settle();
    check("t1_valid_count", vcyc.size(), 1);
    check("t1_valid_cycle", (vcyc.size() > 0) ? vcyc[0] : -1, n + 3);
    check("t1_cutoff", 32'(cut_o), exp_cut(512));
    check("t1_quality", 32'(q_o), 100);

    // Slew-limited climb toward 1023.
    cut_raw = 10'd1023;
    for (int k = 1; k <= 10; k++) begin
      strobe_n(1, 512 + 4 * k, 100, n);
      settle();
      if (k == 1) check("t2_first_step", 32'(cut_o), exp_cut(516));
    end
    check("t2_ten_steps", 32'(cut_o), exp_cut(552));

    // Deadband holds small jitter; larger move goes in one step.
    q_raw = 10'd102;
    strobe_n(1, 556, 100, n);
    settle();
    check("t3_deadband", 32'(q_o), 100);
    q_raw = 10'd103;
    strobe_n(1, 560, 103, n);
    settle();
    check("t3_jump", 32'(q_o), 103);

    // Map boundary points, reached by snapping after reset.
    foreach (pts[j]) begin
      cut_raw = 10'(pts[j]);
      reset_pulse();
      strobe_n(1, pts[j], 103, n);
      settle();
      check("t5_map_point", 32'(cut_o), exp_cut(pts[j]));
    end

    // Back-to-back strobes collapse into one pending update.
    for (int len = 2; len <= 3; len++) begin
      vcyc.delete();
      strobe_n(len, 1023, 103, n);
      settle();
      check("t4_valid_count", vcyc.size(), 2);
      check("t4_first_valid", (vcyc.size() > 0) ? vcyc[0] : -1, n + 3);
      check("t4_second_valid", (vcyc.size() > 1) ? vcyc[1] : -1, n + 7);
    end

    // Asynchronous reset during MAP aborts the update silently.
    cut_raw = 10'd300;
    q_raw   = 10'd50;
    vcyc.delete();
    @(posedge clk); #1;
    strobe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0;
    @(posedge clk); #1;
    check("t6_busy_in_map", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_cutoff", 32'(cut_o), 0);
    check("t6_rst_quality", 32'(q_o), 0);
    check("t6_rst_valid", 32'(valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_valid", vcyc.size(), 0);
    strobe_n(1, 300, 50, n);
    settle();
    check("t6_snap_cutoff", 32'(cut_o), exp_cut(300));
    check("t6_snap_quality", 32'(q_o), 50);

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/filter_param_conditioner.md
Name: filter_param_conditioner

Overview:
Upstream neighbour of the 4-pole ladder audio filter. It turns raw 10-bit pot readings (cutoff, quality) into clean, stable parameters for that filter. Processing chain: deadband rejects ADC jitter, slew limiting stops zipper noise, optional exponential cutoff map. Outputs change only on a per-sample update strobe, so the filter sees constant parameters for a whole sample computation.

Parameters:
SLEW_STEP, 4, max change per update of each slewed value (10-bit units)
DEADBAND, 2, raw-vs-target difference at or below which the target is not updated

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
pot_cutoff_raw  input  10  unsigned raw cutoff pot reading
pot_quality_raw  input  10  unsigned raw resonance pot reading
update_strobe  input  1  one-cycle pulse; driven by filter sample_out_valid
pot_cutoff  output  10  conditioned cutoff to filter
pot_quality  output  10  conditioned quality to filter
params_valid  output  1  one-cycle pulse when outputs have just updated
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs are 0. Targets, current values and the pending flag are cleared. first_load is set. State is IDLE.
- Target stage, runs every cycle, per channel:
  - first_load=1: target loads raw unconditionally; first_load clears after one cycle.
  - Otherwise: if |raw - target| > DEADBAND, target <= raw; else target holds.
  - Compare in 11-bit signed.
- FSM states: IDLE, SLEW, MAP, OUT.
  - IDLE: update_strobe or pending goes to SLEW; pending clears.
  - SLEW: per channel, cur moves toward target by min(|target-cur|, SLEW_STEP). No overshoot; saturate 0..1023. The first SLEW after reset snaps cur to target.
  - MAP: compute the cutoff mapping from slewed cur and register the result.
  - OUT: pot_cutoff/pot_quality take the new values and params_valid=1 for this single cycle. Next state is IDLE.
- Latency: strobe sampled in IDLE at cycle N gives new outputs and params_valid in cycle N+3. Outputs stay stable in every other cycle.
- Strobe while busy: set pending. Pending is serviced from the next IDLE, so valid arrives at N+7 for a second strobe at N+1. Any number of strobes while busy collapse into one pending.
- Async reset mid-operation: immediate return to reset values. No params_valid pulse for the aborted update.
- pot_quality output is always the slewed quality value; it is never mapped.

Optional Feature:
Macro CUTOFF_EXP_MAP_EN.
- Defined: cutoff maps piecewise-linearly over 9 knots K = {4,8,16,32,64,128,256,512,1023}.
  - i = cur[9:7], f = cur[6:0].
  - out = K[i] + (((K[i+1]-K[i]) * f) >> 7).
  - The product is registered in MAP.
- Undefined: cutoff output equals the slewed cur. MAP becomes a pass-through cycle, so latency stays 3.

Decomposition:
- Package filter_param_pkg holds:
  - POT_W = 10
  - the EXP_KNOTS constant array
  - the FSM state enum
- Sub-module pot_slew implements deadband, target and slew for one channel.
  - It is instantiated twice: cutoff and quality.
  - It exposes a slew_en input and a cur output.
- The top level holds the FSM, pending logic and the map.

Test Plan:
1. Reset; raw cutoff=512, quality=100; strobe at N -> params_valid only at N+3; pot_quality=100; pot_cutoff=64 (map on).
2. After 1, raw cutoff=1023, one strobe -> cur 516, pot_cutoff=66 (map on) / 516 (map off). Ten strobes total -> cur 552.
3. Quality raw 100->102 -> after strobe pot_quality stays 100. Raw 103 -> next strobe pot_quality=103 in one step.
4. Strobes at N and N+1 -> params_valid at N+3 and N+7 only. Strobes at N, N+1, N+2 -> same two pulses.
5. Map on, slewed cutoff 0 / 128 / 1023 -> pot_cutoff 4 / 8 / 1019.
6. Assert rst asynchronously during MAP -> outputs 0 same cycle, no params_valid. After release, the next strobe snaps to the current raw values.
